// File: rtl/draw_scheduler.sv
// draw_scheduler
//   Per-frame sequencer for the player / alien-group / laser draw engines.
//   On an accepted frame tick it starts each draw stage in index order and
//   waits for that stage's done (or a cycle timeout) before starting the next.
//   A latched fire-button press is delivered as a one-cycle fire pulse
//   immediately before the laser stage's start pulse.
//
// Ports
//   clock        : single clock, all logic on posedge
//   reset        : asynchronous, active-high
//   frame_tick   : one-cycle pulse per video frame
//   fire_btn     : synchronized fire button level
//   stage_done   : per-stage level done
//   stage_start  : one-hot, one-cycle start pulse per stage
//   fire         : one-cycle fire pulse to the laser stage
//   busy         : sequence in progress
//   cur_stage    : active stage index, 0 when idle
//   frame_count  : completed sequences, wraps 255 -> 0
//   overrun      : sticky, frame tick arrived while a sequence was running
//   timeout      : sticky, a stage failed to report done in time
module draw_scheduler #(
  parameter int unsigned NUM_STAGES     = 3,
  parameter int unsigned LASER_STAGE    = 2,
  parameter int unsigned FRAME_DIV      = 1,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  frame_tick,
  input  logic                  fire_btn,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_start,
  output logic                  fire,
  output logic                  busy,
  output logic [1:0]            cur_stage,
  output logic [7:0]            frame_count,
  output logic                  overrun,
  output logic                  timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRE,
    S_START,
    S_WAIT
  } state_t;

  localparam logic [1:0]  LAST_STAGE = 2'(NUM_STAGES - 1);
  localparam logic [1:0]  LASER_IDX  = 2'(LASER_STAGE);
  localparam logic [7:0]  DIV_LAST   = 8'(FRAME_DIV - 1);
  localparam logic [15:0] TO_LIMIT   = 16'(TIMEOUT_CYCLES);

  state_t      r_state;
  state_t      w_state_nx;
  logic [1:0]  r_cur_stage;
  logic [7:0]  r_div;
  logic [15:0] r_cnt;
  logic        r_fire_pending;
  logic        r_fire_btn_q;
  logic [7:0]  r_frame_count;
  logic        r_overrun;
  logic        r_timeout;

  logic        w_fire_rise;
  logic        w_done;
  logic        w_timed_out;
  logic        w_advance;
  logic        w_last;
  logic        w_accept;
  logic        w_launch;
  logic [1:0]  w_stage_nx;

  // Done of the active stage only; other stages' done levels are ignored.
  always_comb begin
    w_done = 1'b0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (r_cur_stage == 2'(i)) begin
        w_done = stage_done[i];
      end
    end
  end

  assign w_fire_rise = fire_btn & ~r_fire_btn_q;
  assign w_timed_out = (r_cnt == TO_LIMIT);
  assign w_advance   = (r_state == S_WAIT) && (w_done || w_timed_out);
  assign w_last      = (r_cur_stage == LAST_STAGE);
  assign w_accept    = (r_state == S_IDLE) && frame_tick;
  assign w_launch    = w_accept && (r_div == DIV_LAST);
  assign w_stage_nx  = r_cur_stage + 2'd1;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_launch) begin
          w_state_nx = ((LASER_IDX == 2'd0) && r_fire_pending) ? S_FIRE : S_START;
        end
      end
      S_FIRE:  w_state_nx = S_START;
      S_START: w_state_nx = S_WAIT;
      S_WAIT: begin
        if (w_advance) begin
          if (w_last) begin
            w_state_nx = S_IDLE;
          end else if ((w_stage_nx == LASER_IDX) && r_fire_pending) begin
            w_state_nx = S_FIRE;
          end else begin
            w_state_nx = S_START;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Outputs decode directly from registers so an asynchronous reset
  // silences them in the same instant.
  always_comb begin
    stage_start = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      stage_start[i] = (r_state == S_START) && (r_cur_stage == 2'(i));
    end
  end

  assign fire        = (r_state == S_FIRE);
  assign busy        = (r_state != S_IDLE);
  assign cur_stage   = r_cur_stage;
  assign frame_count = r_frame_count;
  assign overrun     = r_overrun;
  assign timeout     = r_timeout;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cur_stage    <= '0;
      r_div          <= '0;
      r_cnt          <= '0;
      r_fire_pending <= 1'b0;
      r_fire_btn_q   <= 1'b0;
      r_frame_count  <= '0;
      r_overrun      <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_fire_btn_q <= fire_btn;

      // A new press wins over the clear so a press during FIRE is not lost.
      if (w_fire_rise) begin
        r_fire_pending <= 1'b1;
      end else if (r_state == S_FIRE) begin
        r_fire_pending <= 1'b0;
      end

      if (frame_tick && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end

      if (w_accept) begin
        r_div <= w_launch ? '0 : r_div + 8'd1;
      end

      if (w_launch) begin
        r_cur_stage <= '0;
      end

      if (r_state == S_START) begin
        r_cnt <= '0;
      end else if ((r_state == S_WAIT) && !w_advance) begin
        r_cnt <= r_cnt + 16'd1;
      end

      if (w_advance) begin
        if (!w_done) begin
          r_timeout <= 1'b1;
        end
        if (w_last) begin
          r_frame_count <= r_frame_count + 8'd1;
          r_cur_stage   <= '0;
        end else begin
          r_cur_stage <= w_stage_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_draw_scheduler.sv
module tb_draw_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       fire_btn;
  logic [2:0] stage_done;
  logic [2:0] stage_start;
  logic       fire;
  logic       busy;
  logic [1:0] cur_stage;
  logic [7:0] frame_count;
  logic       overrun;
  logic       timeout;

  logic       tick2;
  logic [2:0] done2;
  logic [2:0] start2;
  logic       fire2;
  logic       busy2;
  logic [1:0] stage2;
  logic [7:0] fc2;
  logic       ovr2;
  logic       to2;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  draw_scheduler #(
    .NUM_STAGES    (3),
    .LASER_STAGE   (2),
    .FRAME_DIV     (1),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .frame_tick (frame_tick),
    .fire_btn   (fire_btn),
    .stage_done (stage_done),
    .stage_start(stage_start),
    .fire       (fire),
    .busy       (busy),
    .cur_stage  (cur_stage),
    .frame_count(frame_count),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  draw_scheduler #(
    .NUM_STAGES    (3),
    .LASER_STAGE   (2),
    .FRAME_DIV     (2),
    .TIMEOUT_CYCLES(8)
  ) dut2 (
    .clock      (clock),
    .reset      (reset),
    .frame_tick (tick2),
    .fire_btn   (1'b0),
    .stage_done (done2),
    .stage_start(start2),
    .fire       (fire2),
    .busy       (busy2),
    .cur_stage  (stage2),
    .frame_count(fc2),
    .overrun    (ovr2),
    .timeout    (to2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issues a tick in relative cycle 0 and runs until busy drops (bounded).
  // dN: cycles from stage N's start to its one-cycle done pulse (-1: never).
  // Records the first cycle of each start pulse, the fire pulse and idle.
  task automatic run_seq(input int d0, input int d1, input int d2,
                         input int extra_tick, input int press_at,
                         output int s0, output int s1, output int s2,
                         output int f, output int idle_at);
    int st[3];
    int due[3];
    int dly[3];
    dly = '{d0, d1, d2};
    st  = '{-1, -1, -1};
    due = '{-1, -1, -1};
    f = -1;
    idle_at = -1;
    frame_tick = 1'b1;
    for (int c = 1; c <= 200 && idle_at < 0; c++) begin
      step();
      frame_tick = (c == extra_tick);
      fire_btn   = (c == press_at);
      stage_done = '0;
      if (fire && f < 0) f = c;
      for (int i = 0; i < 3; i++) begin
        if (stage_start[i] && st[i] < 0) begin
          st[i] = c;
          if (dly[i] >= 0) due[i] = c + dly[i];
        end
        if (due[i] == c) stage_done[i] = 1'b1;
      end
      if (!busy) idle_at = c;
    end
    frame_tick = 1'b0;
    fire_btn   = 1'b0;
    stage_done = '0;
    s0 = st[0];
    s1 = st[1];
    s2 = st[2];
  endtask

  task automatic seq_fast();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (7) step();
  endtask

  initial begin
    int s0, s1, s2, f, idl;

    reset      = 1'b1;
    frame_tick = 1'b0;
    fire_btn   = 1'b0;
    stage_done = '0;
    tick2      = 1'b0;
    done2      = '0;
    repeat (2) step();

    chk("rst_start", int'(stage_start), 0);
    chk("rst_fire", int'(fire), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_stage", int'(cur_stage), 0);
    chk("rst_fc", int'(frame_count), 0);
    chk("rst_ovr", int'(overrun), 0);
    chk("rst_to", int'(timeout), 0);
    reset = 1'b0;
    step();

    // Basic frame: dones 3 cycles after each start.
    run_seq(3, 3, 3, -1, -1, s0, s1, s2, f, idl);
    chk("t1_s0", s0, 1);
    chk("t1_s1", s1, 5);
    chk("t1_s2", s2, 9);
    chk("t1_nofire", f, -1);
    chk("t1_idle", idl, 13);
    chk("t1_fc", int'(frame_count), 1);
    chk("t1_stage", int'(cur_stage), 0);

    // Stage 1 never completes: 9 WAIT cycles then advance.
    chk("to_pre", int'(timeout), 0);
    run_seq(3, -1, 3, -1, -1, s0, s1, s2, f, idl);
    chk("to_s1", s1, 5);
    chk("to_s2", s2, 15);
    chk("to_idle", idl, 19);
    chk("to_flag", int'(timeout), 1);
    chk("to_fc", int'(frame_count), 2);

    // Press before the tick; second press during stage 2 of frame A.
    fire_btn = 1'b1;
    step();
    fire_btn = 1'b0;
    step();
    run_seq(3, 3, 3, -1, 11, s0, s1, s2, f, idl);
    chk("fa_fire", f, 9);
    chk("fa_s2", s2, 10);
    chk("fa_idle", idl, 14);
    run_seq(3, 3, 3, -1, -1, s0, s1, s2, f, idl);
    chk("fb_fire", f, 9);
    chk("fb_s2", s2, 10);
    run_seq(3, 3, 3, -1, -1, s0, s1, s2, f, idl);
    chk("fc_nofire", f, -1);
    chk("fc_s2", s2, 9);
    chk("fc_idle", idl, 13);
    chk("fc_fc", int'(frame_count), 5);

    // Tick during WAIT of stage 1.
    chk("ov_pre", int'(overrun), 0);
    run_seq(3, 3, 3, 6, -1, s0, s1, s2, f, idl);
    chk("ov_s0", s0, 1);
    chk("ov_s1", s1, 5);
    chk("ov_s2", s2, 9);
    chk("ov_idle", idl, 13);
    chk("ov_flag", int'(overrun), 1);
    repeat (5) step();
    chk("ov_nobusy", int'(busy), 0);
    chk("ov_fc", int'(frame_count), 6);

    // Wrap: 6 + 249 = 255, then one more -> 0.
    stage_done = '1;
    for (int n = 0; n < 249; n++) seq_fast();
    chk("wr_255", int'(frame_count), 255);
    seq_fast();
    chk("wr_0", int'(frame_count), 0);
    stage_done = '0;
    step();

    // FRAME_DIV=2: every second accepted tick launches a sequence.
    done2 = '1;
    for (int k = 0; k < 4; k++) begin
      tick2 = 1'b1;
      step();
      tick2 = 1'b0;
      chk("dv_busy", int'(busy2), (k % 2 == 1) ? 1 : 0);
      repeat (9) step();
    end
    chk("dv_fc", int'(fc2), 2);
    chk("dv_ovr", int'(ovr2), 0);
    done2 = '0;

    // Reset during WAIT of stage 1.
    stage_done = '1;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (3) step();
    chk("mr_stage_pre", int'(cur_stage), 1);
    chk("mr_busy_pre", int'(busy), 1);
    reset = 1'b1;
    #1;
    chk("mr_busy", int'(busy), 0);
    chk("mr_stage", int'(cur_stage), 0);
    chk("mr_start", int'(stage_start), 0);
    chk("mr_fire", int'(fire), 0);
    chk("mr_flags", int'({overrun, timeout}), 0);
    chk("mr_fc", int'(frame_count), 0);
    step();
    step();
    chk("mr_start_hold", int'(stage_start), 0);
    reset      = 1'b0;
    stage_done = '0;
    step();
    run_seq(3, 3, 3, -1, -1, s0, s1, s2, f, idl);
    chk("mr_s0", s0, 1);
    chk("mr_idle", idl, 13);
    chk("mr_fc_after", int'(frame_count), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/draw_scheduler.md
# draw_scheduler

Per-frame sequencer that sits directly upstream of the sprite/laser draw engines. On each frame tick it starts the draw stages one at a time (player, alien group, laser) and waits for each stage's done before starting the next. It also latches the player fire button and delivers it to the laser stage as a single-cycle `fire` pulse just before that stage starts. Sticky overrun and timeout flags report frames that cannot complete in time.

## Interface
Parameters:
- `NUM_STAGES`, 3: number of draw stages, started in index order 0..NUM_STAGES-1.
- `LASER_STAGE`, 2: index of the stage that receives `fire`.
- `FRAME_DIV`, 1: run one sequence every FRAME_DIV accepted frame ticks (1..255).
- `TIMEOUT_CYCLES`, 65535: maximum WAIT cycles per stage; 16-bit counter.

Ports:
- `clock`  in  1: single clock, all logic on posedge.
- `reset`  in  1: asynchronous, active-high.
- `frame_tick`  in  1: one-cycle pulse per video frame (vsync-derived).
- `fire_btn`  in  1: synchronized fire button level.
- `stage_done`  in  NUM_STAGES: level done from each stage, e.g. `out_laser_done`.
- `stage_start`  out  NUM_STAGES: one-hot, one-cycle start pulse, e.g. `laser_draw_reset`.
- `fire`  out  1: one-cycle fire pulse to the laser stage.
- `busy`  out  1: high from the first start pulse until return to IDLE.
- `cur_stage`  out  2: index of the active stage; 0 when idle.
- `frame_count`  out  8: completed sequences, wraps 255 -> 0.
- `overrun`  out  1: sticky; a frame tick arrived while not IDLE.
- `timeout`  out  1: sticky; a stage exceeded TIMEOUT_CYCLES.

## Operation
- States: IDLE, FIRE, START, WAIT.
- IDLE:
  - On `frame_tick`, increment the divider.
  - When the divider reaches FRAME_DIV, clear it, set `cur_stage`=0, and go to START. If stage 0 is LASER_STAGE and fire is pending, go to FIRE instead.
- FIRE:
  - `fire`=1 for this cycle only.
  - Clear `fire_pending`, then go to START.
- START:
  - `stage_start[cur_stage]`=1 for this cycle only.
  - Clear the timeout counter, then go to WAIT.
- WAIT:
  - If `stage_done[cur_stage]`=1, or the counter has reached TIMEOUT_CYCLES: advance.
    - On timeout, also set the `timeout` flag.
    - Advance means: if this was the last stage, increment `frame_count` and go to IDLE. Otherwise increment `cur_stage` and go to START, or to FIRE if the new stage is LASER_STAGE and fire is pending.
  - Otherwise increment the counter.
- Fire latch:
  - A rising edge on `fire_btn` (registered previous value) sets `fire_pending`.
  - A rising edge in the same cycle that FIRE clears the latch leaves `fire_pending`=1.
  - Pending fire survives across frames until the next laser stage.
- `frame_tick` outside IDLE sets `overrun` and is dropped; the divider is not incremented.
- A tick in the same cycle as the last stage's done counts as an overrun.
- Sticky flags clear only on reset.
- `busy` = (state != IDLE).

## Timing
- Reset values: state IDLE, all outputs 0, divider 0, `fire_pending` 0, previous `fire_btn` sample 0, counter 0.
- Reset asserted mid-sequence aborts immediately: no further start or fire pulses.
- Tick accepted in cycle T (FRAME_DIV=1, no fire pending): `stage_start[0]` in T+1, `busy` high from T+1.
- `stage_done` is ignored in the START cycle and sampled from the first WAIT cycle. A stale done from the previous frame is therefore ignored: downstream done deasserts one cycle after its start pulse.
- Done seen in WAIT cycle W: next `stage_start` in W+1, or W+2 when a FIRE cycle is inserted.
- Last done in cycle W: IDLE in W+1, `busy` low in W+1, `frame_count` updated in W+1.
- Timeout: with no done, advance in the cycle where the counter equals TIMEOUT_CYCLES, i.e. TIMEOUT_CYCLES+1 WAIT cycles.
- `fire` and the laser `stage_start` never share a cycle. `fire` always precedes that stage's start by exactly one cycle.

## Test plan
- Reset, then tick at T; all dones pulse 3 cycles after their start: starts at T+1, T+5, T+9; `frame_count`=1 and `busy`=0 at T+13.
- `fire_btn` rises before the tick: `fire` occurs exactly one cycle before `stage_start[2]`, then `fire_pending`=0. A second press during stage 2 gives `fire` in the next frame only.
- `stage_done[1]` held at 0 with TIMEOUT_CYCLES=8: `timeout`=1 after 9 WAIT cycles, then stage 2 starts and the sequence completes.
- Tick during WAIT: `overrun`=1, sequence unaffected, no extra sequence started.
- FRAME_DIV=2, four ticks in IDLE: exactly two sequences, `frame_count`=2. `frame_count` wraps 255 -> 0 after 256 sequences.
- Reset pulsed during WAIT of stage 1: all outputs 0 immediately; the next tick restarts at stage 0.
